mash_decimator: RTL and testbench

Recovers the fractional frequency word from the 3-bit MASH 1-1 modulator output stream. It decodes each `dn` symbol to a signed step in {-1, 0, +1, +2} and filters it with a third-order CIC (sinc³) decimator. The result is normalised back to the `BITS`-wide fraction scale, saturated, and emitted once per decimation period with a valid pulse. It sits at the far end of the modulator link and serves as the loopback/monitor decoder for PLL bring-up and regression.

---
 rtl/mash_decimator_if.sv | 32 +++
 rtl/mash_decimator.sv | 155 +++++++++++++++
 tb/tb_mash_decimator.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mash_decimator_if.sv
// mash_decimator_if: symbol/result bundle between a MASH 1-1 symbol source and
// the sinc^3 decoder.
//   clr     - synchronous restart (source -> decoder)
//   dn      - 3-bit modulator symbol (source -> decoder)
//   f_out   - recovered fraction, unsigned, saturated (decoder -> source)
//   f_valid - one-cycle pulse when f_out updates (decoder -> source)
//   err     - sticky illegal-symbol flag (decoder -> source)
interface mash_decimator_if #(
    parameter int unsigned BITS = 8
);
    logic            clr;
    logic [2:0]      dn;
    logic [BITS-1:0] f_out;
    logic            f_valid;
    logic            err;

    modport master (
        output clr,
        output dn,
        input  f_out,
        input  f_valid,
        input  err
    );

    modport slave (
        input  clr,
        input  dn,
        output f_out,
        output f_valid,
        output err
    );
endinterface

// File: rtl/mash_decimator.sv
// mash_decimator: recovers the fractional frequency word from a MASH 1-1 symbol
// stream. Symbols are decoded to {-1,0,+1,+2}, filtered by a sinc^3 CIC
// decimator (ratio 2^LOG2R), normalised to BITS, saturated and emitted once
// per decimation period.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of mash_decimator_if (clr, dn in; f_out, f_valid, err out)
module mash_decimator #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned LOG2R = 4
) (
    input logic             clk,
    input logic             rst_n,
    mash_decimator_if.slave bus
);
    localparam int unsigned W     = 3 + 3 * LOG2R;
    localparam int unsigned SHIFT = 3 * LOG2R - BITS;

    logic signed [2:0] x_dec;
    logic              illegal;
    logic signed [2:0] x_q, x_d;
    logic [W-1:0]      i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic [LOG2R-1:0]  cnt_q, cnt_d;
    logic              strobe;
    logic [W-1:0]      s_q, s_d;
    logic [W-1:0]      sdly_q, sdly_d, c1dly_q, c1dly_d, c2dly_q, c2dly_d;
    logic [W-1:0]      c3_q, c3_d;
    logic [W-1:0]      c1, c2;
    logic              stb1_q, stb1_d, stb2_q, stb2_d;
    logic [1:0]        warm_q, warm_d;
    logic [BITS-1:0]   f_out_q, f_out_d;
    logic              f_valid_q, f_valid_d;
    logic              err_q, err_d;
    logic signed [W-1:0] y;
    logic [BITS-1:0]   y_sat;

    // dn[2] set means -1 whatever the low bits; 3'b011 is the only illegal code.
    always_comb begin
        x_dec   = 3'sd0;
        illegal = 1'b0;
        if (bus.dn[2]) begin
            x_dec = -3'sd1;
        end else begin
            case (bus.dn[1:0])
                2'b01:   x_dec = 3'sd1;
                2'b10:   x_dec = 3'sd2;
                2'b11:   illegal = 1'b1;
                default: x_dec = 3'sd0;
            endcase
        end
    end

    // Normalise the comb output and clamp into the unsigned fraction range.
    always_comb begin
        y = $signed(c3_q) >>> SHIFT;
        if (y[W-1]) begin
            y_sat = '0;
        end else if (|y[W-2:BITS]) begin
            y_sat = '1;
        end else begin
            y_sat = y[BITS-1:0];
        end
    end

    assign strobe = &cnt_q;
    assign c1     = s_q - sdly_q;
    assign c2     = c1 - c1dly_q;

    always_comb begin
        x_d   = x_dec;
        // Integrators wrap modulo 2^W on purpose; the comb differences undo it.
        i1_d  = i1_q + {{(W-3){x_q[2]}}, x_q};
        i2_d  = i2_q + i1_q;
        i3_d  = i3_q + i2_q;
        cnt_d = cnt_q + 1'b1;
        s_d   = strobe ? i3_q : s_q;
        warm_d = (strobe && (warm_q != 2'd3)) ? warm_q + 2'd1 : warm_q;
        stb1_d = strobe;
        stb2_d = stb1_q;
        sdly_d  = sdly_q;
        c1dly_d = c1dly_q;
        c2dly_d = c2dly_q;
        c3_d    = c3_q;
        if (stb1_q) begin
            sdly_d  = s_q;
            c1dly_d = c1;
            c2dly_d = c2;
            c3_d    = c2 - c2dly_q;
        end
        // Suppress output until the sinc^3 window has been filled once.
        f_valid_d = stb2_q && (warm_q == 2'd3);
        f_out_d   = f_valid_d ? y_sat : f_out_q;
        err_d     = err_q | illegal;
        if (bus.clr) begin
            x_d       = '0;
            i1_d      = '0;
            i2_d      = '0;
            i3_d      = '0;
            cnt_d     = '0;
            s_d       = '0;
            warm_d    = '0;
            stb1_d    = 1'b0;
            stb2_d    = 1'b0;
            sdly_d    = '0;
            c1dly_d   = '0;
            c2dly_d   = '0;
            c3_d      = '0;
            f_valid_d = 1'b0;
            f_out_d   = '0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            i1_q      <= '0;
            i2_q      <= '0;
            i3_q      <= '0;
            cnt_q     <= '0;
            s_q       <= '0;
            warm_q    <= '0;
            stb1_q    <= 1'b0;
            stb2_q    <= 1'b0;
            sdly_q    <= '0;
            c1dly_q   <= '0;
            c2dly_q   <= '0;
            c3_q      <= '0;
            f_valid_q <= 1'b0;
            f_out_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            x_q       <= x_d;
            i1_q      <= i1_d;
            i2_q      <= i2_d;
            i3_q      <= i3_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            warm_q    <= warm_d;
            stb1_q    <= stb1_d;
            stb2_q    <= stb2_d;
            sdly_q    <= sdly_d;
            c1dly_q   <= c1dly_d;
            c2dly_q   <= c2dly_d;
            c3_q      <= c3_d;
            f_valid_q <= f_valid_d;
            f_out_q   <= f_out_d;
            err_q     <= err_d;
        end
    end

    assign bus.f_out   = f_out_q;
    assign bus.f_valid = f_valid_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_mash_decimator.sv
// tb_mash_decimator: directed self-checking bench for mash_decimator
// (BITS=8, LOG2R=4, R=16). Edges are counted from reset release; the first
// valid pulse is expected on edge 3R+2.
module tb_mash_decimator;
    localparam int unsigned BITS  = 8;
    localparam int unsigned LOG2R = 4;
    localparam int          R     = 16;
    localparam int          FIRST = 3 * R + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mash_decimator_if #(.BITS(BITS)) bus ();

    mash_decimator #(
        .BITS (BITS),
        .LOG2R(LOG2R)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ecount = 0;
    int mode   = 0;  // 0: hold dn, 1: alternate 001/000, 2: MASH 1-1 model
    int acc1   = 0;
    int acc2   = 0;
    int c2p    = 0;
    int mod_f  = 0;

    function automatic logic [2:0] enc(input int v);
        case (v)
            -1:      return 3'b111;
            0:       return 3'b000;
            1:       return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

    // Reference MASH 1-1 modulator, 8-bit accumulators.
    task automatic mod_step(output logic [2:0] d);
        int c1, c2;
        acc1 = acc1 + mod_f;
        c1   = (acc1 >= 256) ? 1 : 0;
        acc1 = acc1 % 256;
        acc2 = acc2 + acc1;
        c2   = (acc2 >= 256) ? 1 : 0;
        acc2 = acc2 % 256;
        d    = enc(c1 + c2 - c2p);
        c2p  = c2;
    endtask

    task automatic cycle();
        logic [2:0] d;
        @(posedge clk);
        #1;
        ecount++;
        if (mode == 1) begin
            bus.dn = (bus.dn == 3'b001) ? 3'b000 : 3'b001;
        end else if (mode == 2) begin
            mod_step(d);
            bus.dn = d;
        end
    endtask

    // Reset the DUT, set up the stimulus source; next edge is edge 1.
    task automatic start(input int m, input logic [2:0] d0);
        logic [2:0] d;
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        bus.clr = 1'b0;
        mode    = m;
        bus.dn  = d0;
        acc1    = 0;
        acc2    = 0;
        c2p     = 0;
        if (m == 2) begin
            mod_step(d);
            bus.dn = d;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        ecount = 0;
    endtask

    task automatic wait_pulse(input int max_cyc, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            cycle();
            if (bus.f_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        bus.clr = 1'b0;
        bus.dn  = 3'b011;
        #1;
        checks++;
        if (bus.f_out !== 8'd0) begin
            errors++; $display("FAIL reset_f_out: got %0d expected 0", bus.f_out);
        end
        checks++;
        if (bus.f_valid !== 1'b0) begin
            errors++; $display("FAIL reset_f_valid: got %b expected 0", bus.f_valid);
        end
        checks++;
        if (bus.err !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b expected 0", bus.err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.err !== 1'b0) begin
            errors++; $display("FAIL reset_hold_err: got %b expected 0", bus.err);
        end
    endtask

    task automatic test_zero();
        logic exp_v;
        start(0, 3'b000);
        for (int e = 1; e <= FIRST + 4 * R; e++) begin
            cycle();
            exp_v = (ecount >= FIRST) && (((ecount - FIRST) % R) == 0);
            checks++;
            if (bus.f_valid !== exp_v) begin
                errors++;
                $display("FAIL zero_valid edge %0d: got %b expected %b", ecount, bus.f_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (bus.f_out !== 8'd0 || bus.err !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_out edge %0d: got f_out %0d err %b expected 0 0",
                             ecount, bus.f_out, bus.err);
                end
            end
        end
    endtask

    // Alternating 1/0 for longer than 2^15 cycles: integrators wrap many times.
    task automatic test_half_scale();
        bit got;
        start(1, 3'b001);
        wait_pulse(FIRST + 4, got);
        checks++;
        if (!got || ecount != FIRST) begin
            errors++; $display("FAIL half_first: got edge %0d expected %0d", ecount, FIRST);
        end
        for (int p = 1; p <= 2100; p++) begin
            wait_pulse(R + 2, got);
            checks++;
            if (!got || ecount != FIRST + p * R || bus.f_out !== 8'd128) begin
                errors++;
                $display("FAIL half_pulse %0d: got edge %0d f_out %0d expected edge %0d f_out 128",
                         p, ecount, bus.f_out, FIRST + p * R);
            end
        end
    endtask

    task automatic test_saturation();
        bit got;
        start(0, 3'b001);
        for (int p = 0; p < 40; p++) begin
            wait_pulse((p == 0) ? FIRST + 4 : R + 2, got);
            checks++;
            if (!got || bus.f_out !== 8'd255) begin
                errors++;
                $display("FAIL sat_high %0d: got valid %b f_out %0d expected 255", p, got, bus.f_out);
            end
        end
        start(0, 3'b111);
        for (int p = 0; p < 8; p++) begin
            wait_pulse((p == 0) ? FIRST + 4 : R + 2, got);
            checks++;
            if (!got || bus.f_out !== 8'd0) begin
                errors++;
                $display("FAIL sat_low %0d: got valid %b f_out %0d expected 0", p, got, bus.f_out);
            end
        end
    endtask

    task automatic test_loopback();
        bit got;
        int fs[3];
        int sum, diff;
        fs[0] = 64;
        fs[1] = 100;
        fs[2] = 200;
        for (int k = 0; k < 3; k++) begin
            mod_f = fs[k];
            start(2, 3'b000);
            sum = 0;
            for (int p = 1; p <= 20; p++) begin
                wait_pulse((p == 1) ? FIRST + 4 : R + 2, got);
                if (p > 4) begin
                    diff = int'(bus.f_out) - mod_f;
                    sum  = sum + int'(bus.f_out);
                    checks++;
                    if (!got || diff > 2 || diff < -2) begin
                        errors++;
                        $display("FAIL loop_f%0d pulse %0d: got %0d expected %0d+-2",
                                 mod_f, p, bus.f_out, mod_f);
                    end
                end
            end
            diff = sum - 16 * mod_f;
            checks++;
            if (diff > 16 || diff < -16) begin
                errors++;
                $display("FAIL loop_avg_f%0d: got sum %0d expected %0d+-16", mod_f, sum, 16 * mod_f);
            end
        end
    endtask

    task automatic test_illegal();
        bit got;
        start(0, 3'b000);
        wait_pulse(FIRST + 4, got);
        repeat (5) cycle();
        bus.dn = 3'b011;
        checks++;
        if (bus.err !== 1'b0) begin
            errors++; $display("FAIL ill_before: got %b expected 0", bus.err);
        end
        cycle();
        bus.dn = 3'b000;
        checks++;
        if (bus.err !== 1'b1) begin
            errors++; $display("FAIL ill_set: got %b expected 1", bus.err);
        end
        for (int p = 0; p < 2; p++) begin
            wait_pulse(R + 2, got);
            checks++;
            if (!got || bus.f_out !== 8'd0 || bus.err !== 1'b1) begin
                errors++;
                $display("FAIL ill_sticky %0d: got valid %b f_out %0d err %b expected 1 0 1",
                         p, got, bus.f_out, bus.err);
            end
        end
        bus.clr = 1'b1;
        cycle();
        bus.clr = 1'b0;
        checks++;
        if (bus.err !== 1'b0) begin
            errors++; $display("FAIL ill_clr: got %b expected 0", bus.err);
        end
        bus.dn  = 3'b011;
        bus.clr = 1'b1;
        cycle();
        bus.clr = 1'b0;
        bus.dn  = 3'b000;
        checks++;
        if (bus.err !== 1'b0) begin
            errors++; $display("FAIL ill_with_clr: got %b expected 0", bus.err);
        end
        cycle();
        checks++;
        if (bus.err !== 1'b0) begin
            errors++; $display("FAIL ill_with_clr_next: got %b expected 0", bus.err);
        end
    endtask

    // use_clr=0: asynchronous reset just after strobe edge S; 1: clr on edge S+1.
    task automatic test_restart(input bit use_clr);
        bit got;
        int p_edge;
        start(0, 3'b001);
        wait_pulse(FIRST + 4, got);
        repeat (3) wait_pulse(R + 2, got);
        p_edge = ecount;
        while (ecount < p_edge + R - 2) cycle();
        if (!use_clr) begin
            rst_n = 1'b0;
            #1;
        end else begin
            bus.clr = 1'b1;
            cycle();
            bus.clr = 1'b0;
        end
        checks++;
        if (bus.f_out !== 8'd0 || bus.f_valid !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL restart%0d_out: got f_out %0d valid %b err %b expected 0 0 0",
                     use_clr, bus.f_out, bus.f_valid, bus.err);
        end
        if (!use_clr) begin
            repeat (2) begin
                cycle();
                checks++;
                if (bus.f_valid !== 1'b0) begin
                    errors++; $display("FAIL restart0_cancel: got %b expected 0", bus.f_valid);
                end
            end
            rst_n  = 1'b1;
            ecount = 0;
        end else begin
            ecount = 0;
            cycle();
            checks++;
            if (bus.f_valid !== 1'b0) begin
                errors++; $display("FAIL restart1_cancel: got %b expected 0", bus.f_valid);
            end
        end
        wait_pulse(FIRST + 4, got);
        checks++;
        if (!got || ecount != FIRST || bus.f_out !== 8'd255) begin
            errors++;
            $display("FAIL restart%0d_first: got valid %b edge %0d f_out %0d expected edge %0d f_out 255",
                     use_clr, got, ecount, bus.f_out, FIRST);
        end
    endtask

    initial begin
        bus.clr = 1'b0;
        bus.dn  = 3'b000;
        test_reset();
        test_zero();
        test_half_scale();
        test_saturation();
        test_loopback();
        test_illegal();
        test_restart(1'b0);
        test_restart(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
